// File: rtl/half_adder_if.sv
// half_adder_if
//   Bundles the lane operands, sample qualifier, counter clear and all
//   results of the half-adder lane array.
//   Parameters: WIDTH (lanes), CNT_W (carry-event counter width).
//   Modports:
//     master : drives a, b, in_valid, count_clr; observes results.
//     slave  : the adder; observes operands, drives sum/carry,
//              sum_q/carry_q/out_valid and carry_count.
interface half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             count_clr;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_count;

    modport master (
        output a, b, in_valid, count_clr,
        input  sum, carry, sum_q, carry_q, out_valid, carry_count
    );

    modport slave (
        input  a, b, in_valid, count_clr,
        output sum, carry, sum_q, carry_q, out_valid, carry_count
    );
endinterface

// File: rtl/half_adder.sv
// half_adder
//   Array of WIDTH independent half-adder lanes. sum/carry are purely
//   combinational; sum_q/carry_q are a one-cycle registered copy of the
//   last accepted sample (in_valid=1), with out_valid marking the cycle
//   after each accept. carry_count is a saturating count of accepted
//   samples with any carry bit set; count_clr clears it synchronously
//   and takes priority over an increment.
//   Ports:
//     clk   : rising-edge clock for all registered state
//     rst_n : asynchronous active-low reset
//     bus   : half_adder_if.slave (operands, qualifier, results)

// One lane: combinational half add plus enabled result register.
module half_adder_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic en,
    output logic sum,
    output logic carry,
    output logic sum_q,
    output logic carry_q
);
    assign sum   = a ^ b;
    assign carry = a & b;

    // Registered copy holds when no sample is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sum;
            carry_q <= carry;
        end
    end
endmodule

module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    half_adder_if.slave  bus
);
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] carry_w;
    logic [WIDTH-1:0] sum_q_w;
    logic [WIDTH-1:0] carry_q_w;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt;
    logic             any_carry;
    logic             cnt_full;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .a       (bus.a[i]),
            .b       (bus.b[i]),
            .en      (bus.in_valid),
            .sum     (sum_w[i]),
            .carry   (carry_w[i]),
            .sum_q   (sum_q_w[i]),
            .carry_q (carry_q_w[i])
        );
    end

    assign any_carry = |carry_w;
    assign cnt_full  = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
        end
    end

    // Clear beats increment, so a carrying sample in the clear cycle is
    // dropped. Counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.count_clr) begin
            cnt <= '0;
        end else if (bus.in_valid && any_carry && !cnt_full) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.sum         = sum_w;
    assign bus.carry       = carry_w;
    assign bus.sum_q       = sum_q_w;
    assign bus.carry_q     = carry_q_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.carry_count = cnt;
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder
//   Directed-vector bench for half_adder. Three instances share clk/rst_n:
//     d1 : WIDTH=1, CNT_W=16 (truth table, registered path, counter, reset)
//     d4 : WIDTH=4, CNT_W=16 (multi-lane)
//     ds : WIDTH=1, CNT_W=2  (saturation)
//   Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_half_adder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    half_adder_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
    half_adder_if #(.WIDTH(4), .CNT_W(16)) bus4 ();
    half_adder_if #(.WIDTH(1), .CNT_W(2))  buss ();

    half_adder #(.WIDTH(1), .CNT_W(16)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    half_adder #(.WIDTH(4), .CNT_W(16)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    half_adder #(.WIDTH(1), .CNT_W(2))  u_ds (.clk(clk), .rst_n(rst_n), .bus(buss));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // a,b packed as {a,b}; expected {sum,carry}
    logic [1:0] tt_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.in_valid = 1'b0; bus1.count_clr = 1'b0;
        bus4.a = '0; bus4.b = '0; bus4.in_valid = 1'b0; bus4.count_clr = 1'b0;
        buss.a = '0; buss.b = '0; buss.in_valid = 1'b0; buss.count_clr = 1'b0;

        // Reset state
        #2;
        chk("rst_sum_q",     32'(bus1.sum_q), 32'd0);
        chk("rst_carry_q",   32'(bus1.carry_q), 32'd0);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_count",     32'(bus1.carry_count), 32'd0);
        chk("rst_count4",    32'(bus4.carry_count), 32'd0);
        chk("rst_counts",    32'(buss.carry_count), 32'd0);
        #20 rst_n = 1'b1;

        // Exhaustive truth table, 5 ns apart
        for (int i = 0; i < 4; i++) begin
            bus1.a = i[1];
            bus1.b = i[0];
            #4;
            chk($sformatf("tt_sum_%0d", i),   32'(bus1.sum),   32'(tt_exp[i][1]));
            chk($sformatf("tt_carry_%0d", i), 32'(bus1.carry), 32'(tt_exp[i][0]));
            #1;
        end

        // Registered path: one sample 1+1
        step();
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0;
        chk("reg_sum_q",     32'(bus1.sum_q), 32'd0);
        chk("reg_carry_q",   32'(bus1.carry_q), 32'd1);
        chk("reg_out_valid", 32'(bus1.out_valid), 32'd1);
        chk("reg_count",     32'(bus1.carry_count), 32'd1);
        step();
        chk("reg_out_valid_drop", 32'(bus1.out_valid), 32'd0);
        chk("reg_carry_q_hold",   32'(bus1.carry_q), 32'd1);
        chk("reg_count_hold",     32'(bus1.carry_count), 32'd1);

        // Multi-lane
        bus4.a = 4'b1100; bus4.b = 4'b1010; bus4.in_valid = 1'b1;
        #1;
        chk("ml_sum",   32'(bus4.sum),   32'h6);
        chk("ml_carry", 32'(bus4.carry), 32'h8);
        step();
        bus4.in_valid = 1'b0;
        chk("ml_sum_q",   32'(bus4.sum_q),   32'h6);
        chk("ml_carry_q", 32'(bus4.carry_q), 32'h8);
        chk("ml_count",   32'(bus4.carry_count), 32'd1);

        // Counter: clear, then carries 1,0,1,1 back to back
        bus1.count_clr = 1'b1;
        step();
        bus1.count_clr = 1'b0;
        chk("cnt_clr_idle", 32'(bus1.carry_count), 32'd0);
        bus1.in_valid = 1'b1;
        bus1.a = 1'b1; bus1.b = 1'b1; step();
        bus1.a = 1'b1; bus1.b = 1'b0; step();
        chk("cnt_ov_cont", 32'(bus1.out_valid), 32'd1);
        chk("cnt_sum_q_10", 32'(bus1.sum_q), 32'd1);
        bus1.a = 1'b1; bus1.b = 1'b1; step();
        bus1.a = 1'b1; bus1.b = 1'b1; step();
        chk("cnt_four", 32'(bus1.carry_count), 32'd3);
        // Clear with a carrying sample: clear wins
        bus1.count_clr = 1'b1;
        step();
        bus1.count_clr = 1'b0; bus1.in_valid = 1'b0;
        chk("cnt_clr_wins", 32'(bus1.carry_count), 32'd0);
        chk("cnt_clr_ov",   32'(bus1.out_valid), 32'd1);

        // Saturation at CNT_W=2
        buss.a = 1'b1; buss.b = 1'b1; buss.in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("sat_%0d", k), 32'(buss.carry_count), (k > 3) ? 32'd3 : 32'(k));
        end
        buss.in_valid = 1'b0;

        // Async reset mid-stream
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.in_valid = 1'b1;
        step();
        step();
        chk("ar_pre_ov",  32'(bus1.out_valid), 32'd1);
        chk("ar_pre_cnt", 32'(bus1.carry_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sum_q",   32'(bus1.sum_q), 32'd0);
        chk("ar_carry_q", 32'(bus1.carry_q), 32'd0);
        chk("ar_ov",      32'(bus1.out_valid), 32'd0);
        chk("ar_cnt",     32'(bus1.carry_count), 32'd0);
        chk("ar_counts",  32'(buss.carry_count), 32'd0);
        chk("ar_carry_comb", 32'(bus1.carry), 32'd1);
        bus1.b = 1'b0;
        #1;
        chk("ar_sum_comb",    32'(bus1.sum), 32'd1);
        chk("ar_carry_comb0", 32'(bus1.carry), 32'd0);
        bus1.b = 1'b1;
        step();
        chk("ar_hold_cnt", 32'(bus1.carry_count), 32'd0);
        chk("ar_hold_ov",  32'(bus1.out_valid), 32'd0);
        #3 rst_n = 1'b1;
        step();
        chk("ar_resume_cnt", 32'(bus1.carry_count), 32'd1);
        chk("ar_resume_ov",  32'(bus1.out_valid), 32'd1);
        bus1.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/half_adder.md
# half_adder

Bitwise half-adder lane array with zero-latency combinational outputs and a one-cycle registered copy with valid tracking. It also keeps a saturating count of accepted samples that produced a carry. It is the leaf arithmetic primitive in the gate-level datapath; wider adders chain its `sum`/`carry` outputs, and the registered side feeds pipelined consumers.

## Interface
- `WIDTH`, 1: number of independent half-adder lanes.
- `CNT_W`, 16: width of the carry-event counter.

Ports:
- `clk`  in  1  rising-edge clock for all registered state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  WIDTH  addend A, one bit per lane.
- `b`  in  WIDTH  addend B, one bit per lane.
- `sum`  out  WIDTH  combinational `a ^ b`.
- `carry`  out  WIDTH  combinational `a & b`.
- `in_valid`  in  1  qualifies `a`/`b` for the registered path and counter.
- `sum_q`  out  WIDTH  registered `sum` of the last accepted sample.
- `carry_q`  out  WIDTH  registered `carry` of the last accepted sample.
- `out_valid`  out  1  high for one cycle after each accepted sample.
- `count_clr`  in  1  synchronous clear of `carry_count`.
- `carry_count`  out  CNT_W  number of accepted samples with any carry bit set, saturating.

## Operation
- Per lane i: `sum[i] = a[i] XOR b[i]`, `carry[i] = a[i] AND b[i]`.
  - Truth table: 00→(0,0), 01→(1,0), 10→(1,0), 11→(0,1).
  - Purely combinational and independent of `clk`, `rst_n` and `in_valid`.
  - Lanes never interact; there is no carry-in.
- Accept: at a rising `clk` edge with `in_valid`=1, the block latches `sum_q`←`a^b`, `carry_q`←`a&b` and `out_valid`←1.
- When `in_valid`=0 at an edge:
  - `out_valid`←0.
  - `sum_q` and `carry_q` hold their last value.
- Counter update at each rising edge, in priority order:
  - `count_clr`=1 → `carry_count`←0. Clear wins over a simultaneous increment, so that sample is not counted.
  - Else, if `in_valid`=1 and `|(a&b)`=1 and `carry_count` is not all-ones → increment by 1.
  - Else hold. At all-ones the counter saturates and holds; it never wraps.
- Reset (`rst_n`=0, asynchronous):
  - `sum_q`, `carry_q`, `out_valid` and `carry_count` clear to 0 immediately.
  - `sum`/`carry` keep following the inputs during reset.
- Reset release: state updates resume at the first rising edge with `rst_n`=1.
- Inputs X/Z are not specified; the bench drives known values only.

## Timing
- `sum`/`carry`: zero-cycle latency, valid after combinational settle.
- `sum_q`/`carry_q`/`out_valid`: one-cycle latency from the accepting edge.
- No backpressure; every `in_valid` cycle is accepted. Back-to-back `in_valid` gives `out_valid` continuously high.
- `carry_count` reflects a sample at the edge that accepts it, so it is visible one cycle after the inputs are presented.
- Reset asserted mid-stream: outputs clear within the same cycle, without waiting for a clock edge. Any sample in flight is discarded and not counted.

## Test plan
- Exhaustive combinational check (WIDTH=1), 5 ns apart, `a,b` = 00, 01, 10, 11 → `sum,carry` = 0,0; 1,0; 1,0; 0,1, each settling before the next change.
- Registered path: `in_valid`=1 for one cycle with a=1, b=1 → next cycle `sum_q`=0, `carry_q`=1, `out_valid`=1. The following cycle `out_valid`=0 and `carry_q` holds 1.
- Multi-lane (WIDTH=4): a=4'b1100, b=4'b1010 → `sum`=4'b0110, `carry`=4'b1000. After one accepted cycle `carry_count` increments by 1.
- Counter rules:
  - Four accepted samples, carries 1, 0, 1, 1 → `carry_count`=3.
  - Then `count_clr`=1 together with a carrying sample → `carry_count`=0.
  - With CNT_W=2, five carrying samples → count stops at 3.
- Async reset mid-operation:
  - Drop `rst_n` between clock edges while `out_valid`=1 and `carry_count`=2 → all registered outputs 0 before the next edge.
  - `sum`/`carry` still track `a`/`b` throughout.
